// File: rtl/wrr_arb_pkg.sv
// rtl/wrr_arb_pkg.sv - shared types and helpers for the weighted round-robin arbiter
package wrr_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  // A zero weight still earns one beat so a client can never be starved by its own config.
  function automatic int unsigned eff_weight(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick_first.sv
// rtl/rr_pick_first.sv - circular first-requester search starting at a given index
module rr_pick_first #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  // Lower copy is masked below start, upper copy supplies the wrap-around; lowest hit wins.
  always_comb begin
    dbl    = {req, req};
    masked = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < 2 * N; i++) begin
      masked[i] = dbl[i] && (i >= int'(start));
    end
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (masked[i]) begin
        found = 1'b1;
        idx   = (i >= N) ? IDX_W'(i - N) : IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// rtl/weighted_rr_arbiter.sv - weighted round-robin arbiter with grant hold; optional WRR_ARB_LOCK_EN adds lock input
module weighted_rr_arbiter
  import wrr_arb_pkg::*;
#(
  parameter  int NUM_CLIENTS = 4,
  parameter  int WEIGHT_W    = 4,
  localparam int IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CLIENTS-1:0]          req,
  input  logic [NUM_CLIENTS*WEIGHT_W-1:0] weight,
  input  logic                            gnt_ready,
`ifdef WRR_ARB_LOCK_EN
  input  logic [NUM_CLIENTS-1:0]          lock,
`endif
  output logic [NUM_CLIENTS-1:0]          grant,
  output logic                            grant_valid,
  output logic [IDX_W-1:0]                grant_idx
);

  arb_state_e          state;
  logic [IDX_W-1:0]    pointer;
  logic [WEIGHT_W-1:0] credit;

  logic                owner_req;
  logic                lock_hold;
  logic                beat;
  logic                expire;
  logic                release_w;
  logic [IDX_W-1:0]    next_idx;
  logic [IDX_W-1:0]    scan_start;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [WEIGHT_W-1:0] pick_weight;

  // Owner handshake: beat accounting, credit expiry and the release decision.
  always_comb begin
    owner_req = req[grant_idx];
`ifdef WRR_ARB_LOCK_EN
    lock_hold = lock[grant_idx];
`else
    lock_hold = 1'b0;
`endif
    beat       = (state == ARB_GRANT) && gnt_ready && owner_req;
    expire     = beat && (credit == WEIGHT_W'(1)) && !lock_hold;
    release_w  = (state == ARB_GRANT) && (!owner_req || expire);
    next_idx   = (grant_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant_idx + 1'b1;
    scan_start = release_w ? next_idx : pointer;
  end

  rr_pick_first #(
    .N (NUM_CLIENTS)
  ) u_pick (
    .req   (req),
    .start (scan_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Weight of the candidate being loaded, sampled only at grant load time.
  always_comb begin
    pick_weight = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_weight = WEIGHT_W'(eff_weight(32'(weight[i*WEIGHT_W +: WEIGHT_W])));
      end
    end
  end

  // Arbitration FSM: load a new owner when idle or on release, else count beats down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      pointer     <= '0;
      credit      <= '0;
    end else if (state == ARB_IDLE || release_w) begin
      if (release_w) begin
        pointer <= next_idx;
      end
      if (pick_found) begin
        state       <= ARB_GRANT;
        grant       <= NUM_CLIENTS'(1) << pick_idx;
        grant_valid <= 1'b1;
        grant_idx   <= pick_idx;
        credit      <= pick_weight;
      end else begin
        state       <= ARB_IDLE;
        grant       <= '0;
        grant_valid <= 1'b0;
      end
    end else if (beat && credit != WEIGHT_W'(1)) begin
      // A locked owner at credit 1 falls through here and saturates.
      credit <= credit - 1'b1;
    end
  end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb/tb_weighted_rr_arbiter.sv - randomized model-checked bench for weighted_rr_arbiter
module tb_weighted_rr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;
  localparam int IW = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*WW-1:0] weight;
  logic          gnt_ready;
`ifdef WRR_ARB_LOCK_EN
  logic [N-1:0]  lock;
`endif
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: owner (-1 when idle), beats left, rotation pointer, last index.
  int m_owner;
  int m_left;
  int m_ptr;
  int m_idx;

  weighted_rr_arbiter #(
    .NUM_CLIENTS (N),
    .WEIGHT_W    (WW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .weight      (weight),
    .gnt_ready   (gnt_ready),
`ifdef WRR_ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int w_of(input int c);
    int w;
    w = int'(weight[c*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic bit lock_of(input int c);
`ifdef WRR_ARB_LOCK_EN
    return lock[c];
`else
    return (c < 0);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model advance: rules applied with plain integers each rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1;
      m_left  <= 0;
      m_ptr   <= 0;
      m_idx   <= 0;
    end else begin
      int o, l, p, s, c;
      bit need, rel;
      o = m_owner; l = m_left; p = m_ptr; s = p; need = 0; rel = 0;
      if (o < 0) begin
        need = 1;
      end else begin
        rel = !req[o];
        if (gnt_ready && req[o]) begin
          if (l == 1) begin
            if (!lock_of(o)) rel = 1;
          end else begin
            l = l - 1;
          end
        end
        if (rel) begin
          p = (o + 1) % N;
          s = p;
          need = 1;
        end
      end
      if (need) begin
        o = -1;
        for (int k = 0; k < N; k++) begin
          c = (s + k) % N;
          if (o < 0 && req[c]) o = c;
        end
        if (o >= 0) begin
          l = w_of(o);
          m_idx <= o;
        end
      end
      m_owner <= o;
      m_left  <= l;
      m_ptr   <= p;
    end
  end

  // Compare process: DUT outputs against the model every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("grant", int'(grant), (m_owner >= 0) ? (1 << m_owner) : 0);
      chk("grant_valid", int'(grant_valid), (m_owner >= 0) ? 1 : 0);
      chk("grant_idx", int'(grant_idx), m_idx);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_grant", int'(grant), 0);
    chk("rst_valid", int'(grant_valid), 0);
    chk("rst_idx", int'(grant_idx), 0);
    rst = 1'b0;
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic expect_idx(input string name, input int exp);
    @(negedge clk);
    chk({name, "_dut"}, int'(grant_idx), exp);
    chk({name, "_model"}, m_idx, exp);
    chk({name, "_valid"}, int'(grant_valid), 1);
  endtask

  initial begin
    int seq1[5];
    int seq2[8];
    rst = 1'b1;
    req = '0;
    gnt_ready = 1'b0;
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
`ifdef WRR_ARB_LOCK_EN
    lock = '0;
`endif
    #12;

    // All weights 1, everyone requesting: strict rotation with no bubbles.
    do_reset();
    seq1 = '{0, 1, 2, 3, 0};
    req = 4'b1111; gnt_ready = 1'b1;
    foreach (seq1[i]) expect_idx("t1_rot", seq1[i]);

    // Client 0 weight 3 against client 1 weight 1.
    do_reset();
    seq2 = '{0, 0, 0, 1, 0, 0, 0, 1};
    weight = {4'd1, 4'd1, 4'd1, 4'd3};
    req = 4'b0011; gnt_ready = 1'b1;
    foreach (seq2[i]) expect_idx("t2_wrr", seq2[i]);

    // Client 2 with credit 3 held through 5 stalled cycles, then exactly 3 beats.
    do_reset();
    weight = {4'd1, 4'd3, 4'd1, 4'd1};
    req = 4'b1100; gnt_ready = 1'b0;
    for (int i = 0; i < 6; i++) expect_idx("t3_hold", 2);
    gnt_ready = 1'b1;
    expect_idx("t3_beat1", 2);
    expect_idx("t3_beat2", 2);
    expect_idx("t3_rot", 3);

    // Owner 1 drops its request; scan resumes at 2.
    do_reset();
    weight = {4'd1, 4'd1, 4'd5, 4'd1};
    req = 4'b0010; gnt_ready = 1'b1;
    expect_idx("t4_own", 1);
    expect_idx("t4_own2", 1);
    req = 4'b1001;
    expect_idx("t4_next", 3);
    expect_idx("t4_wrap", 0);

    // Weight 0 behaves as 1; a sole requester is re-granted back to back.
    do_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd0};
    req = 4'b0001; gnt_ready = 1'b1;
    for (int i = 0; i < 3; i++) expect_idx("t5_w0", 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_grant", int'(grant), 0);
    chk("t5_async_valid", int'(grant_valid), 0);
    req = '0;
    #1 rst = 1'b0;

`ifdef WRR_ARB_LOCK_EN
    // Lock keeps client 1 beyond its weight; dropping lock releases on the next beat.
    do_reset();
    weight = {4'd1, 4'd1, 4'd2, 4'd1};
    lock = 4'b0010;
    req = 4'b0010; gnt_ready = 1'b1;
    expect_idx("t6_own", 1);
    req = 4'b0011;
    for (int i = 0; i < 6; i++) expect_idx("t6_lock", 1);
    lock = 4'b0000;
    expect_idx("t6_rel", 0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      req = N'($urandom);
      if ($urandom_range(0, 3) == 0) req = '0;
      gnt_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) begin
        for (int c = 0; c < N; c++) weight[c*WW +: WW] = WW'($urandom_range(0, 3));
      end
`ifdef WRR_ARB_LOCK_EN
      lock = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
`endif
    end
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
